// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the I/D cache memory arbiter.
//   state_t     - arbiter FSM states (IDLE, GNT_I, GNT_D)
//   side_t      - which cache side was served last
//   BLOCK_WORDS - words fetched per cache block fill
//   BASE_MASK   - mask turning a miss address into its block base
//   MEM_LATENCY - cycles from mem_enable to the matching mem_data_valid
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam int          BLOCK_WORDS = 8;
  localparam logic [15:0] BASE_MASK   = 16'hFFF0;
  localparam int          MEM_LATENCY = 4;

  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return addr & BASE_MASK;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side signals of the arbiter.
//   slave  modport - the arbiter's view (requests and memory returns in,
//                    grants, data_valids, data_out and read strobe out)
//   master modport - the environment's view (caches + memory)
//
// Handshake semantics: a *_req is a level held by the cache fill FSM while
// it wants a block; the matching *_grant rises the cycle after the arbiter
// accepts it and stays high until the last word of the block has returned.
// mem_enable is a one-cycle read strobe per word (no back-pressure); the
// memory answers every strobe with exactly one mem_data_valid cycle a fixed
// latency later. *_data_valid qualifies data_out for one cycle per word.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic        icache_req;
  logic [15:0] icache_addr;
  logic        dcache_req;
  logic [15:0] dcache_addr;
  logic        icache_grant;
  logic        dcache_grant;
  logic        icache_data_valid;
  logic        dcache_data_valid;
  logic [15:0] data_out;
  logic        mem_enable;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data;

  modport slave (
    input  icache_req, icache_addr, dcache_req, dcache_addr,
           mem_data_valid, mem_data,
    output icache_grant, dcache_grant, icache_data_valid, dcache_data_valid,
           data_out, mem_enable, mem_addr
  );

  modport master (
    output icache_req, icache_addr, dcache_req, dcache_addr,
           mem_data_valid, mem_data,
    input  icache_grant, dcache_grant, icache_data_valid, dcache_data_valid,
           data_out, mem_enable, mem_addr
  );

endinterface

// File: rtl/mem_arbiter_counter.sv
// arb_counter: 3-bit word counter used for both issued reads and returns.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - synchronous clear (wins over en)
//   en       - count one word
//   count    - current value
//   tc       - high while count is on the last word of a block
module arb_counter
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] count,
  output logic       tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 3'd1;
    end
  end

  assign tc = (count == 3'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory between the I-cache and D-cache
// fill engines. A granted side gets one 8-word block: 8 back-to-back reads
// at base + 2*k, and the returns are steered to that side's data_valid.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - mem_arbiter_if.slave (cache requests/grants, memory port)
//   dbg_state - current FSM state
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output state_t        dbg_state
);

  state_t      state, state_n;
  side_t       last_served;
  logic [15:0] base;
  logic [15:0] addr_hold;
  logic [15:0] issue_addr;
  logic        issue_done;
  logic        icache_grant_q, dcache_grant_q;
  logic [2:0]  issue_cnt, ret_cnt;
  logic        issue_tc, ret_tc;
  logic        busy, issuing, ret_fire, fill_done;

  assign busy      = (state != IDLE);
  // Reads go out on the first 8 cycles of a grant, then stop until IDLE.
  assign issuing   = busy && !issue_done;
  // Returns outside a grant (stale after reset, or spurious) are dropped.
  assign ret_fire  = busy && bus.mem_data_valid;
  assign fill_done = ret_fire && ret_tc;
  // 16-bit wrap: a block at FFF0 ends at FFFE without touching the next block.
  assign issue_addr = base + {12'd0, issue_cnt, 1'b0};

  arb_counter u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!busy),
    .en    (issuing),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  arb_counter u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!busy),
    .en    (ret_fire),
    .count (ret_cnt),
    .tc    (ret_tc)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.icache_req && bus.dcache_req) begin
          // Tie: serve whichever side did not get the previous block.
          state_n = (last_served == SIDE_I) ? GNT_D : GNT_I;
        end else if (bus.icache_req) begin
          state_n = GNT_I;
        end else if (bus.dcache_req) begin
          state_n = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (fill_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_served    <= SIDE_I;
      base           <= '0;
      addr_hold      <= '0;
      issue_done     <= 1'b0;
      icache_grant_q <= 1'b0;
      dcache_grant_q <= 1'b0;
    end else begin
      state          <= state_n;
      icache_grant_q <= (state_n == GNT_I);
      dcache_grant_q <= (state_n == GNT_D);
      if (state == IDLE && state_n == GNT_I) base <= block_base(bus.icache_addr);
      if (state == IDLE && state_n == GNT_D) base <= block_base(bus.dcache_addr);
      if (fill_done) last_served <= (state == GNT_D) ? SIDE_D : SIDE_I;
      if (issuing) addr_hold <= issue_addr;
      if (!busy) begin
        issue_done <= 1'b0;
      end else if (issuing && issue_tc) begin
        issue_done <= 1'b1;
      end
    end
  end

  assign bus.icache_grant      = icache_grant_q;
  assign bus.dcache_grant      = dcache_grant_q;
  assign bus.mem_enable        = issuing;
  assign bus.mem_addr          = issuing ? issue_addr : addr_hold;
  assign bus.icache_data_valid = (state == GNT_I) && bus.mem_data_valid;
  assign bus.dcache_data_valid = (state == GNT_D) && bus.mem_data_valid;
  assign bus.data_out          = bus.mem_data;
  assign dbg_state             = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter with a fixed-latency memory model,
// a block-level reference model and directed/random stimulus.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic [15:0] da;
    logic [1:0]  exp_side;  // 01 = I granted, 10 = D granted
    logic [15:0] exp_base;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic   clk    = 1'b0;
  logic   rst    = 1'b1;
  logic   inject = 1'b0;
  state_t dbg_state;
  int     n_cmp  = 0;
  int     n_err  = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- memory model: fixed-latency read pipe ----------------
  logic [16:0] sr [MEM_LATENCY];
  initial for (int i = 0; i < MEM_LATENCY; i++) sr[i] = '0;

  always @(posedge clk) begin
    sr[0] <= {bus.mem_enable, bus.mem_addr};
    for (int i = 1; i < MEM_LATENCY; i++) sr[i] <= sr[i-1];
  end

  assign bus.mem_data_valid = sr[MEM_LATENCY-1][16] | inject;
  assign bus.mem_data       = mem_word(sr[MEM_LATENCY-1][15:0]);

  // ---------------- scoreboard / reference model ----------------
  // Block level: whoever is granted is owed 8 reads base+2k and 8 words in
  // that order; a fill ends after its 8th word and the next IDLE cycle's
  // requests decide the following owner.
  logic [15:0] addr_q [$];
  logic [15:0] exp_q  [$];
  int          owner = 0;      // 0 none, 1 I, 2 D
  int          m_last = 0;     // 0 I served last, 1 D
  int          rets = 0;
  int          side_m;
  int          fills_started = 0;
  logic [15:0] last_addr = '0;
  logic [15:0] ea, base_m;
  logic        exp_en;

  always @(negedge clk) begin
    if (rst) begin
      owner = 0; rets = 0; m_last = 0; last_addr = '0;
      addr_q.delete(); exp_q.delete();
      chk("rst_icache_grant", bus.icache_grant, 16'd0);
      chk("rst_dcache_grant", bus.dcache_grant, 16'd0);
      chk("rst_icache_dv", bus.icache_data_valid, 16'd0);
      chk("rst_dcache_dv", bus.dcache_data_valid, 16'd0);
      chk("rst_mem_enable", bus.mem_enable, 16'd0);
      chk("rst_mem_addr", bus.mem_addr, 16'h0000);
      chk("rst_data_out", bus.data_out, bus.mem_data);
      chk("rst_state", 16'(dbg_state), 16'(IDLE));
    end else begin
      chk("icache_grant", bus.icache_grant, 16'(owner == 1));
      chk("dcache_grant", bus.dcache_grant, 16'(owner == 2));
      exp_en = (owner != 0) && (addr_q.size() != 0);
      chk("mem_enable", bus.mem_enable, 16'(exp_en));
      if (exp_en && bus.mem_enable) begin
        ea = addr_q.pop_front();
        chk("mem_addr", bus.mem_addr, ea);
        last_addr = ea;
      end else if (!bus.mem_enable) begin
        chk("mem_addr_hold", bus.mem_addr, last_addr);
      end
      chk("icache_dv", bus.icache_data_valid, 16'(owner == 1 && bus.mem_data_valid));
      chk("dcache_dv", bus.dcache_data_valid, 16'(owner == 2 && bus.mem_data_valid));
      chk("data_out", bus.data_out, bus.mem_data);
      if (owner != 0 && bus.mem_data_valid) begin
        if (exp_q.size() != 0) chk("ret_word", bus.data_out, exp_q.pop_front());
        rets++;
      end
      if (owner == 0) begin
        side_m = 0;
        if (bus.icache_req && bus.dcache_req) side_m = (m_last == 0) ? 2 : 1;
        else if (bus.icache_req) side_m = 1;
        else if (bus.dcache_req) side_m = 2;
        if (side_m != 0) begin
          base_m = ((side_m == 1) ? bus.icache_addr : bus.dcache_addr) & 16'hFFF0;
          addr_q.delete(); exp_q.delete();
          for (int k = 0; k < BLOCK_WORDS; k++) begin
            ea = base_m + 16'(2 * k);
            addr_q.push_back(ea);
            exp_q.push_back(mem_word(ea));
          end
          owner = side_m; rets = 0; fills_started++;
        end
      end else if (rets == BLOCK_WORDS) begin
        m_last = owner - 1;
        owner  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_reqs(input logic ir, input logic [15:0] ia, input logic dr, input logic [15:0] da);
    @(posedge clk); #1;
    bus.icache_req = ir; bus.icache_addr = ia;
    bus.dcache_req = dr; bus.dcache_addr = da;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_grant(input string nm, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.icache_grant || bus.dcache_grant) begin ok = 1'b1; break; end
    end
    if (!ok) chk({nm, "_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic wait_release(input string nm);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!bus.icache_grant && !bus.dcache_grant) begin done = 1'b1; break; end
    end
    if (!done) chk({nm, "_timeout"}, 16'd0, 16'd1);
  endtask

  // One request pattern through a complete fill; requests drop after `hold`
  // granted cycles.
  task automatic do_fill(input logic ir, input logic [15:0] ia, input logic dr, input logic [15:0] da,
                         input int hold, output logic [1:0] side, output logic [15:0] base,
                         output int n_en, output int n_dv, output int n_g, output int lat);
    logic ok;
    int   fe, fd;
    n_en = 0; n_dv = 0; n_g = 0; lat = -1; fe = -1; fd = -1; side = '0; base = '0;
    set_reqs(ir, ia, dr, da);
    wait_grant("fill_grant", ok);
    if (ok) begin
      side = {bus.dcache_grant, bus.icache_grant};
      base = bus.mem_addr;
      for (int k = 0; k < 40; k++) begin
        if (!bus.icache_grant && !bus.dcache_grant) break;
        n_g++;
        if (bus.mem_enable) begin n_en++; if (fe < 0) fe = k; end
        if ((side[0] && bus.icache_data_valid) || (side[1] && bus.dcache_data_valid)) begin
          n_dv++; if (fd < 0) fd = k;
        end
        if (k == hold) set_reqs(1'b0, bus.icache_addr, 1'b0, bus.dcache_addr);
        @(negedge clk);
      end
      lat = fd - fe;
    end
    set_reqs(1'b0, 16'h0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [7];
    logic [1:0]  side;
    logic [15:0] base;
    int          n_en, n_dv, n_g, lat, cnt, resid;
    logic        ok;

    bus.icache_req = 1'b0; bus.icache_addr = '0;
    bus.dcache_req = 1'b0; bus.dcache_addr = '0;

    vt[0] = '{1'b1, 16'h0040, 1'b1, 16'h8088, 2'b10, 16'h8080};  // first tie -> D
    vt[1] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 2'b01, 16'h1110};  // alternate -> I
    vt[2] = '{1'b1, 16'h3335, 1'b1, 16'h4447, 2'b10, 16'h4440};  // alternate -> D
    vt[3] = '{1'b1, 16'h1233, 1'b0, 16'h0000, 2'b01, 16'h1230};
    vt[4] = '{1'b0, 16'h0000, 1'b1, 16'hFFF7, 2'b10, 16'hFFF0};
    vt[5] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 2'b01, 16'hFFF0};
    vt[6] = '{1'b1, 16'hABCD, 1'b1, 16'h5A5F, 2'b10, 16'h5A50};  // last I -> D

    repeat (3) @(posedge clk);
    #1;
    chk("init_mem_addr", bus.mem_addr, 16'h0000);
    chk("init_grants", {14'd0, bus.dcache_grant, bus.icache_grant}, 16'd0);
    rst = 1'b0;

    // table-driven fills
    for (int v = 0; v < 7; v++) begin
      do_fill(vt[v].ir, vt[v].ia, vt[v].dr, vt[v].da, 0, side, base, n_en, n_dv, n_g, lat);
      chk($sformatf("vec%0d_side", v), 16'(side), 16'(vt[v].exp_side));
      chk($sformatf("vec%0d_base", v), base, vt[v].exp_base);
      chk($sformatf("vec%0d_enables", v), 16'(n_en), 16'd8);
      chk($sformatf("vec%0d_returns", v), 16'(n_dv), 16'd8);
      chk($sformatf("vec%0d_latency", v), 16'(lat), 16'(MEM_LATENCY));
      chk($sformatf("vec%0d_grant_len", v), 16'(n_g), 16'(BLOCK_WORDS + MEM_LATENCY));
    end

    // tie after reset: D first, I waits and follows after one IDLE cycle
    do_reset();
    set_reqs(1'b1, 16'h0040, 1'b1, 16'h8088);
    wait_grant("tie_grant", ok);
    chk("tie_first_dgrant", bus.dcache_grant, 16'd1);
    chk("tie_first_base", bus.mem_addr, 16'h8080);
    set_reqs(1'b1, 16'h0040, 1'b0, 16'h0000);
    wait_release("tie_release");
    chk("tie_gap_igrant", bus.icache_grant, 16'd0);
    @(negedge clk);
    chk("tie_second_igrant", bus.icache_grant, 16'd1);
    chk("tie_second_base", bus.mem_addr, 16'h0040);
    set_reqs(1'b0, 16'h0, 1'b0, 16'h0);
    wait_release("tie2_release");
    repeat (2) @(negedge clk);

    // request dropped 2 cycles into a fill
    do_fill(1'b0, 16'h0, 1'b1, 16'h7777, 2, side, base, n_en, n_dv, n_g, lat);
    chk("drop_side", 16'(side), 16'b10);
    chk("drop_enables", 16'(n_en), 16'd8);
    chk("drop_returns", 16'(n_dv), 16'd8);

    // reset at the 5th return
    set_reqs(1'b1, 16'h2468, 1'b0, 16'h0);
    wait_grant("rst5_grant", ok);
    cnt = 0;
    for (int k = 0; k < 30 && cnt < 5; k++) begin
      if (bus.icache_data_valid) cnt++;
      if (cnt < 5) @(negedge clk);
    end
    chk("rst5_reached", 16'(cnt), 16'd5);
    #2 rst = 1'b1;
    #1;
    chk("rst5_igrant", bus.icache_grant, 16'd0);
    chk("rst5_idv", bus.icache_data_valid, 16'd0);
    chk("rst5_mem_enable", bus.mem_enable, 16'd0);
    chk("rst5_mem_addr", bus.mem_addr, 16'h0000);
    bus.icache_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    cnt = 0; resid = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_data_valid) resid++;
      if (bus.icache_data_valid || bus.dcache_data_valid) cnt++;
    end
    chk("rst5_residual_seen", 16'(resid > 0), 16'd1);
    chk("rst5_residual_dv", 16'(cnt), 16'd0);

    // stray return in IDLE, then a normal fill must still take 8 returns
    @(posedge clk); #1 inject = 1'b1;
    @(negedge clk);
    chk("inject_mdv", bus.mem_data_valid, 16'd1);
    chk("inject_idv", bus.icache_data_valid, 16'd0);
    chk("inject_ddv", bus.dcache_data_valid, 16'd0);
    @(posedge clk); #1 inject = 1'b0;
    do_fill(1'b1, 16'h0ABC, 1'b0, 16'h0, 0, side, base, n_en, n_dv, n_g, lat);
    chk("post_inject_base", base, 16'h0AB0);
    chk("post_inject_returns", 16'(n_dv), 16'd8);
    chk("post_inject_grant_len", 16'(n_g), 16'(BLOCK_WORDS + MEM_LATENCY));

    // random request traffic against the scoreboard
    fills_started = 0;
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 7) == 0) bus.icache_req = ~bus.icache_req;
      if ($urandom_range(0, 3) == 0) bus.icache_addr = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.dcache_req = ~bus.dcache_req;
      if ($urandom_range(0, 3) == 0) bus.dcache_addr = 16'($urandom);
    end
    set_reqs(1'b0, 16'h0, 1'b0, 16'h0);
    wait_release("rand_release");
    repeat (3) @(negedge clk);
    chk("rand_fills_started", 16'(fills_started > 10), 16'd1);
    chk("rand_addr_q_empty", 16'(addr_q.size()), 16'd0);
    chk("rand_exp_q_empty", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 icache_req  input  1  I-side fill FSM busy, requesting a block.
REQ-005 icache_addr  input  16  I-side miss address.
REQ-006 dcache_req  input  1  D-side fill FSM busy, requesting a block.
REQ-007 dcache_addr  input  16  D-side miss address.
REQ-008 icache_grant  output  1  I-side owns memory.
REQ-009 dcache_grant  output  1  D-side owns memory.
REQ-010 icache_data_valid  output  1  returned word is for the I-side.
REQ-011 dcache_data_valid  output  1  returned word is for the D-side.
REQ-012 data_out  output  16  returned word, broadcast to both sides.
REQ-013 mem_enable  output  1  memory read strobe, one word per cycle.
REQ-014 mem_addr  output  16  memory word address.
REQ-015 mem_data_valid  input  1  memory return strobe; fixed 4-cycle latency, pipelined.
REQ-016 mem_data  input  16  memory return word.

Function
REQ-017 SHALL implement states IDLE, GNT_I and GNT_D.
REQ-018 IDLE with only one request asserted SHALL move to that side's GNT state on the next edge.
REQ-019 IDLE with both requests asserted SHALL grant the side not served last; the last_served register resets to I, so D wins the first tie.
REQ-020 On entering a GNT state, the block SHALL latch base = requester address & 16'hFFF0.
REQ-021 In GNT, the block SHALL assert mem_enable for exactly 8 consecutive cycles, starting the first GNT cycle.
REQ-022 Issued addresses SHALL be mem_addr = base + 2*k, k = 0..7, from a 3-bit issue counter.
REQ-023 Outside those 8 cycles, mem_enable SHALL be 0 and mem_addr SHALL hold the last value.
REQ-024 The granted side's data_valid SHALL equal mem_data_valid combinationally.
REQ-025 data_out SHALL equal mem_data; the other side's data_valid SHALL be 0.
REQ-026 A 3-bit return counter SHALL count returns; on the 8th return the next state SHALL be IDLE and last_served SHALL update.
REQ-027 Minimum gap between consecutive grants SHALL be one IDLE cycle.
REQ-028 Grant outputs SHALL be registered, one-hot or zero.
REQ-029 Grant SHALL be held from GNT entry until the 8th return.
REQ-030 Deassertion of the granted request mid-fill SHALL be ignored; the fill completes.
REQ-031 A request from the other side during a fill SHALL wait.
REQ-032 mem_data_valid in IDLE SHALL be dropped: no data_valid and no counter change.
REQ-033 Address arithmetic SHALL be 16-bit modulo: base 16'hFFF0 issues FFF0..FFFE with no wrap into the next block.

Reset
REQ-034 rst SHALL force IDLE, clear both counters, and set last_served = I.
REQ-035 Under reset, all outputs SHALL be 0: grants, data_valids, mem_enable, mem_addr = 16'h0000; data_out follows mem_data.
REQ-036 Reset mid-fill SHALL abandon the fill.
REQ-037 After reset, returns still in flight SHALL be dropped per REQ-032.

Structure
REQ-038 A shared package SHALL hold the state enum, BLOCK_WORDS = 8, BASE_MASK = 16'hFFF0 and MEM_LATENCY = 4.
REQ-039 One sub-module, arb_counter, SHALL be used: a 3-bit counter with clear, enable and terminal-count output, instantiated for issue and return.

Verification
REQ-040 I-only: icache_req = 1, icache_addr = 16'h1233 -> icache_grant next cycle; mem_addr 1230,1232..123E over 8 cycles; 8 icache_data_valid pulses 4 cycles after each enable; IDLE after the 8th.
REQ-041 Simultaneous request after reset (I 16'h0040, D 16'h8088) -> D granted with base 8080; I granted after D's 8th return plus one IDLE cycle with base 0040.
REQ-042 Back-to-back ties -> grants alternate D, I, D.
REQ-043 dcache_req dropped 2 cycles into a fill -> all 8 enables and 8 dcache_data_valid still occur.
REQ-044 rst asserted at the 5th return -> outputs 0 immediately; residual mem_data_valid pulses produce no data_valid.
REQ-045 Base FFF0 -> last mem_addr FFFE; injected mem_data_valid in IDLE -> ignored.
